wx_mem_arbiter: RTL

//  Shares one single-port W/X memory interface between the host loader (preloads weights/inputs,

---
 rtl/wx_mem_arbiter_pkg.sv | 27 ++
 rtl/wx_mem_arbiter_rr2_pick.sv | 34 +++
 rtl/wx_mem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wx_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : wx_arb_pkg                                                       |
// | Purpose : Shared encodings for the W/X memory arbiter: FSM state, owner    |
// |           identity and the default memory interface widths used by the    |
// |           compute engine, loader and memory model.                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package wx_arb_pkg;

   localparam int C_ADDR_LEN = 20;
   localparam int C_DATA_LEN = 1;
   localparam int C_SEL_LEN  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_H = 2'd1,
      GNT_C = 2'd2
   } arb_state_t;

   typedef enum logic {
      HOST = 1'b0,
      COMP = 1'b1
   } owner_t;

endpackage
`default_nettype wire

// File: rtl/wx_mem_arbiter_rr2_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : arb_rr2_pick                                                     |
// | Purpose : Combinational two-way round-robin pick between host and compute. |
// | Ports   : h_req, c_req   - pending requests                                |
// |           last_owner     - side that held the port most recently          |
// |           pick_valid     - at least one side is requesting                |
// |           pick_owner     - winner (HOST=0 / COMP=1)                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module arb_rr2_pick
   import wx_arb_pkg::*;
(
   input  logic h_req,
   input  logic c_req,
   input  logic last_owner,
   output logic pick_valid,
   output logic pick_owner
);

   always_comb begin
      pick_valid = h_req | c_req;
      // On a tie the side that did not own the port last goes next.
      if (h_req && c_req) begin
         pick_owner = (last_owner == HOST) ? COMP : HOST;
      end else if (c_req) begin
         pick_owner = COMP;
      end else begin
         pick_owner = HOST;
      end
   end

endmodule
`default_nettype wire

// File: rtl/wx_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wx_mem_arbiter                                                   |
// | Purpose : Shares the single-port W/X memory between the host loader and   |
// |           the compute engine. Two-way round-robin, locked bursts with a    |
// |           starvation cap, one IDLE bubble between grants.                  |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           h_* / c_*  - requester side: req, lock, we, addr, sel, wdata,    |
// |                        gnt (out), rvalid (out)                             |
// |           m_*        - memory side: addr, sel, we, wdata (out), rdata (in) |
// |           rdata      - memory read data shared by both requesters          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module wx_mem_arbiter
   import wx_arb_pkg::*;
#(
   parameter int ADDR_LEN  = C_ADDR_LEN,
   parameter int DATA_LEN  = C_DATA_LEN,
   parameter int SEL_LEN   = C_SEL_LEN,
   parameter int MAX_BURST = 16
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                h_req,
   input  logic                h_lock,
   input  logic                h_we,
   input  logic [ADDR_LEN-1:0] h_addr,
   input  logic [SEL_LEN-1:0]  h_sel,
   input  logic [DATA_LEN-1:0] h_wdata,
   output logic                h_gnt,
   output logic                h_rvalid,
   input  logic                c_req,
   input  logic                c_lock,
   input  logic                c_we,
   input  logic [ADDR_LEN-1:0] c_addr,
   input  logic [SEL_LEN-1:0]  c_sel,
   input  logic [DATA_LEN-1:0] c_wdata,
   output logic                c_gnt,
   output logic                c_rvalid,
   output logic [ADDR_LEN-1:0] m_addr,
   output logic [SEL_LEN-1:0]  m_sel,
   output logic                m_we,
   output logic [DATA_LEN-1:0] m_wdata,
   input  logic [DATA_LEN-1:0] m_rdata,
   output logic [DATA_LEN-1:0] rdata
);

   localparam int                CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]  C_CNT_MAX = CNT_W'(MAX_BURST);

   arb_state_t        r_state;
   owner_t            r_last_owner;
   logic [CNT_W-1:0]  r_beat_cnt;
   logic              r_h_rvalid;
   logic              r_c_rvalid;

   logic              w_pick_valid;
   logic              w_pick_owner;
   logic              w_h_beat;
   logic              w_c_beat;
   logic              w_own_req;
   logic              w_own_lock;
   logic              w_other_req;
   logic [CNT_W:0]    w_cnt_inc;
   logic              w_cap_hit;
   logic              w_release;

   arb_rr2_pick u_pick (
      .h_req      (h_req),
      .c_req      (c_req),
      .last_owner (r_last_owner),
      .pick_valid (w_pick_valid),
      .pick_owner (w_pick_owner)
   );

   assign w_h_beat = (r_state == GNT_H) && h_req;
   assign w_c_beat = (r_state == GNT_C) && c_req;

   // Current owner's view of the request pair, so both grant states share one exit rule.
   always_comb begin
      w_own_req   = 1'b0;
      w_own_lock  = 1'b0;
      w_other_req = 1'b0;
      case (r_state)
         GNT_H: begin
            w_own_req   = h_req;
            w_own_lock  = h_lock;
            w_other_req = c_req;
         end
         GNT_C: begin
            w_own_req   = c_req;
            w_own_lock  = c_lock;
            w_other_req = h_req;
         end
         default: ;
      endcase
   end

   // One extra bit so the +1 can never wrap. Compared with >= rather than == so that a
   // burst which already saturated the counter while the other side was idle still
   // yields as soon as the other side starts requesting.
   assign w_cnt_inc = {1'b0, r_beat_cnt} + (CNT_W + 1)'(1);
   assign w_cap_hit = (w_cnt_inc >= {1'b0, C_CNT_MAX});
   assign w_release = !w_own_req || !w_own_lock || (w_other_req && w_cap_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_owner <= HOST;
         r_beat_cnt   <= '0;
         r_h_rvalid   <= 1'b0;
         r_c_rvalid   <= 1'b0;
      end else begin
         // Read data returns one cycle after the beat; tag it to the issuing side.
         r_h_rvalid <= w_h_beat & ~h_we;
         r_c_rvalid <= w_c_beat & ~c_we;
         case (r_state)
            IDLE: begin
               // Grants are only entered from IDLE, so clearing here clears on entry.
               r_beat_cnt <= '0;
               if (w_pick_valid) begin
                  r_state <= (w_pick_owner == COMP) ? GNT_C : GNT_H;
               end
            end
            GNT_H, GNT_C: begin
               if (w_own_req && (r_beat_cnt != C_CNT_MAX)) begin
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
               end
               if (w_release) begin
                  r_state      <= IDLE;
                  r_last_owner <= (r_state == GNT_H) ? HOST : COMP;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Port mux: the memory only sees a transaction on a real beat; otherwise all zero.
   always_comb begin
      m_we    = 1'b0;
      m_addr  = '0;
      m_sel   = '0;
      m_wdata = '0;
      if (w_h_beat) begin
         m_we    = h_we;
         m_addr  = h_addr;
         m_sel   = h_sel;
         m_wdata = h_wdata;
      end else if (w_c_beat) begin
         m_we    = c_we;
         m_addr  = c_addr;
         m_sel   = c_sel;
         m_wdata = c_wdata;
      end
   end

   assign h_gnt    = (r_state == GNT_H);
   assign c_gnt    = (r_state == GNT_C);
   assign h_rvalid = r_h_rvalid;
   assign c_rvalid = r_c_rvalid;
   assign rdata    = m_rdata;

endmodule
`default_nettype wire
